irq_controller: RTL and testbench
=================================

# irq_controller

Single-chip, edge-triggered, fixed-priority interrupt controller mapped at I/O 20h/21h. It is a reduced 8259A register model. It consumes the timer's `intr` on line 0 and the other peripheral request lines on lines 1–7. It raises one interrupt request to the CPU and returns an 8-bit vector on acknowledge.

## Interface
Parameters:
- `NUM_LINES`, 8: number of request lines. Fixed at 8; the parameter exists only for bench sizing.

Ports:
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-low reset.
- `cs` in 1: chip select, high when the I/O address is 20h–21h.
- `data_m_addr` in [1:1]: must be 0. Accesses with this bit set are acked and ignored.
- `data_m_data_in` in 16: lane 0 is port 20h (command); lane 1 is port 21h (data).
- `data_m_data_out` out 16: registered read data; unselected lane reads 0.
- `data_m_bytesel` in 2: lane enables.
- `data_m_wr_en` in 1: write strobe.
- `data_m_access` in 1: access request.
- `data_m_ack` out 1: one-cycle acknowledge.
- `irq` in 8: request lines, synchronous to `clk`, rising-edge sensitive. `irq[0]` carries the timer `intr`.
- `inta` in 1: single-cycle interrupt acknowledge from the CPU.
- `intr` out 1: interrupt request to the CPU.
- `irq_vector` out 8: vector, valid the cycle after `inta`.

## Operation
Registers:
- `irr`: request register.
- `isr`: in-service register.
- `imr`: mask register.
- `vec_base[7:3]`: vector base.
- `rd_isr`: OCW3 read select.
- `irq_prev`: 8-bit copy of `irq` for edge detection.

Request capture:
- A rising edge on any line (`irq & ~irq_prev`) sets the matching `irr` bit.
- Masked lines still latch into `irr`.

Priority:
- Line 0 is highest, line 7 is lowest.
- `pending` = lowest-index set bit of `irr & ~imr`.
- `intr` is registered high when `pending` exists and its index is lower than the lowest set `isr` bit, or `isr` is zero.

Acknowledge (`inta` high):
- If `pending` exists: clear its `irr` bit, set its `isr` bit, and drive `irq_vector` = {`vec_base`, index}.
- If nothing is pending: drive `irq_vector` = {`vec_base`, 3'd7} (spurious) and leave `isr` unchanged.

Writes to port 20h (lane 0):
- Bit 4 set (ICW1): enter ICW2. Clear `irr`, `isr` and `imr`, and set `rd_isr`=0. Latch `need_icw4` = bit 0 and `single` = bit 1.
- Value 20h (non-specific EOI): clear the lowest set `isr` bit.
- Value 6xh (specific EOI): clear `isr[x]`.
- Bits 4:3 = 01 (OCW3): if bit 1 is set, `rd_isr` = bit 0.
- All other values are ignored.

Writes to port 21h (lane 1) depend on the init state machine:
- `READY`: write `imr`.
- `ICW2`: store bits 7:3 into `vec_base`. Go to `ICW3` if `!single`, else `ICW4` if `need_icw4`, else `READY`.
- `ICW3`: value is discarded. Go to `ICW4` if `need_icw4`, else `READY`.
- `ICW4`: value is discarded. Go to `READY`.

Reads:
- Lane 0 returns `rd_isr ? isr : irr`.
- Lane 1 returns `imr`.

## Timing
Reset values:
- `intr`=0, `irq_vector`=0, `data_m_ack`=0, `data_m_data_out`=0.
- `irr`=`isr`=0, `imr`=FFh, `vec_base`=01h (vector 08h), `rd_isr`=0.
- `irq_prev`=FFh, so lines already high at reset do not fire.
- State = `READY`.
- Reset asserted mid-init returns to `READY` with these values.

Latencies:
- `irq` rising edge sampled at edge N sets `irr` at edge N; `intr` goes high at edge N+1.
- `data_m_ack` = registered `cs & data_m_access`, one cycle after the request, for reads and writes.
- Read data is valid in the same cycle as `data_m_ack`.
- `irq_vector` is registered at the `inta` edge and holds until the next `inta`.
- `intr` reflects the updated `irr`/`isr`/`imr` one cycle after any change.

Simultaneous events:
- `inta` and a new edge on the line it services, same cycle: the service consumes the old `irr` bit; the new edge re-sets `irr`.
- EOI write and `inta`, same cycle: the EOI clears the lowest set bit of the pre-cycle `isr`, then the `inta` set bit is applied. Both take effect.
- ICW1 and `inta`, same cycle: ICW1 wins; `isr` ends at 0 and `irq_vector` still updates.
- Write with both lanes enabled: the lane 0 action is applied first, then lane 1, evaluated against the post-lane-0 state.

## Structure
- Package `irq_controller_pkg`:
  - enum `init_state_t` {`READY`, `ICW2`, `ICW3`, `ICW4`}.
  - Constants `OCW2_NS_EOI`=8'h20 and `OCW2_SPEC_EOI`=3'b011.
  - Function `lowest_set(logic [7:0]) -> {valid, idx[2:0]}`.
- Sub-module `irq_priority_resolver`: combinational. Inputs are `irr`, `imr`, `isr`; outputs are `pending_valid` and `pending_idx`. It is used for both the `intr` and `inta` paths.

## Test plan
- Each case runs the init sequence ICW1=13h, ICW2=08h, ICW4=01h (no ICW3) first; after it, reading 21h returns 00h.
- Basic service:
  - Stimulus: write IMR=FEh, then pulse `irq[0]`.
  - Required: `intr`=1 two cycles later. `inta` gives `irq_vector`=08h, `isr`=01h and `intr` drops. A 20h EOI leaves `isr`=00h.
- Priority and nesting:
  - Stimulus: IMR=00h, raise `irq[3]`, then `irq[1]`, then `inta` twice.
  - Required: vectors 09h then 0Bh, `isr`=0Ah. An EOI clears bit 1.
- Masking:
  - Stimulus: IMR=FFh, edge on `irq[5]`.
  - Required: OCW3 0Ah read gives `irr`=20h and `intr` stays 0. Unmasking line 5 raises `intr` the next cycle.
- Spurious and readback:
  - Stimulus: `inta` with nothing pending.
  - Required: vector 0Fh and `isr` unchanged. OCW3 0Bh followed by a read of 20h returns `isr`.
- Boundaries:
  - Stimulus: `irq[2]` edge in the same cycle as an `inta` servicing line 2; separately, EOI and `inta` in the same cycle.
  - Required: the line-2 case re-latches `irr` bit 2; the EOI case applies both the clear and the set. Asserting `reset` mid-ICW2 restores `imr`=FFh and state `READY`.

Source files
------------

// File: rtl/irq_controller_pkg.sv
// Shared types, command constants and a priority helper for the
// reduced 8259A-style interrupt controller.
package irq_controller_pkg;

  typedef enum logic [1:0] {
    READY,
    ICW2,
    ICW3,
    ICW4
  } init_state_t;

  localparam logic [7:0] OCW2_NS_EOI   = 8'h20;
  localparam logic [2:0] OCW2_SPEC_EOI = 3'b011;

  // Returns {valid, index} of the lowest-index set bit; line 0 has top priority.
  function automatic logic [3:0] lowest_set(input logic [7:0] vec);
    logic [3:0] result;
    result = 4'b0000;
    for (int i = 7; i >= 0; i--) begin
      if (vec[i]) begin
        result = {1'b1, 3'(i)};
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/irq_controller_if.sv
// I/O bus seen by the controller at ports 20h/21h. The CPU side drives
// the request, the controller answers with read data and a one-cycle ack.
interface irq_controller_if;

  logic        cs;
  logic [1:1]  data_m_addr;
  logic [15:0] data_m_data_in;
  logic [15:0] data_m_data_out;
  logic [1:0]  data_m_bytesel;
  logic        data_m_wr_en;
  logic        data_m_access;
  logic        data_m_ack;

  modport master (
    output cs, data_m_addr, data_m_data_in, data_m_bytesel, data_m_wr_en, data_m_access,
    input  data_m_data_out, data_m_ack
  );

  modport slave (
    input  cs, data_m_addr, data_m_data_in, data_m_bytesel, data_m_wr_en, data_m_access,
    output data_m_data_out, data_m_ack
  );

endinterface

// File: rtl/irq_controller_priority_resolver.sv
// Picks the highest-priority unmasked request and reports whether it
// outranks everything currently in service.
module irq_priority_resolver
  import irq_controller_pkg::*;
(
  input  logic [7:0] irr,
  input  logic [7:0] imr,
  input  logic [7:0] isr,
  output logic       pending_valid,
  output logic [2:0] pending_idx,
  output logic       pending_allowed
);

  logic [3:0] w_pendLow;
  logic [3:0] w_isrLow;

  // A pending line may interrupt only if it beats the lowest in-service line.
  always_comb begin
    w_pendLow       = lowest_set(irr & ~imr);
    w_isrLow        = lowest_set(isr);
    pending_valid   = w_pendLow[3];
    pending_idx     = w_pendLow[2:0];
    pending_allowed = w_pendLow[3] && (!w_isrLow[3] || (w_pendLow[2:0] < w_isrLow[2:0]));
  end

endmodule

// File: rtl/irq_controller.sv
// Edge-triggered, fixed-priority interrupt controller: register model of a
// single 8259A with ICW1/2/3/4 init, OCW1 mask, OCW2 EOI and OCW3 readback.
module irq_controller
  import irq_controller_pkg::*;
#(
  parameter int NUM_LINES = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  irq_controller_if.slave      bus,
  input  logic [NUM_LINES-1:0] irq,
  input  logic                 inta,
  output logic                 intr,
  output logic [7:0]           irq_vector
);

  init_state_t r_state;
  logic [7:0]  r_irr, r_isr, r_imr, r_irqPrev, r_vector;
  logic [4:0]  r_vecBase;
  logic        r_rdIsr, r_needIcw4, r_single, r_intr, r_ack;
  logic [15:0] r_dataOut;

  init_state_t w_stateNext;
  logic [7:0]  w_irrNext, w_isrNext, w_imrNext, w_vectorNext, w_d0, w_d1;
  logic [4:0]  w_vecBaseNext;
  logic        w_rdIsrNext, w_needIcw4Next, w_singleNext;
  logic        w_pendValid, w_pendAllowed, w_access, w_wrLane0, w_wrLane1, w_rdValid;
  logic [2:0]  w_pendIdx;
  logic [3:0]  w_isrLow;
  logic [15:0] w_dataOutNext;

  irq_priority_resolver u_resolver (
    .irr             (r_irr),
    .imr             (r_imr),
    .isr             (r_isr),
    .pending_valid   (w_pendValid),
    .pending_idx     (w_pendIdx),
    .pending_allowed (w_pendAllowed)
  );

  // Next-state evaluation: acknowledge first, then lane-0 command, then
  // lane-1 data against the post-lane-0 init state. ICW1 overrides the rest.
  always_comb begin
    w_access       = bus.cs && bus.data_m_access;
    w_wrLane0      = w_access && bus.data_m_wr_en && !bus.data_m_addr[1] && bus.data_m_bytesel[0];
    w_wrLane1      = w_access && bus.data_m_wr_en && !bus.data_m_addr[1] && bus.data_m_bytesel[1];
    w_rdValid      = w_access && !bus.data_m_wr_en && !bus.data_m_addr[1];
    w_d0           = bus.data_m_data_in[7:0];
    w_d1           = bus.data_m_data_in[15:8];
    w_isrLow       = lowest_set(r_isr);

    w_irrNext      = r_irr;
    w_isrNext      = r_isr;
    w_imrNext      = r_imr;
    w_vecBaseNext  = r_vecBase;
    w_rdIsrNext    = r_rdIsr;
    w_needIcw4Next = r_needIcw4;
    w_singleNext   = r_single;
    w_stateNext    = r_state;
    w_vectorNext   = r_vector;

    if (inta) begin
      if (w_pendValid) begin
        w_irrNext[w_pendIdx] = 1'b0;
        w_vectorNext         = {r_vecBase, w_pendIdx};
      end else begin
        w_vectorNext = {r_vecBase, 3'd7};
      end
    end

    if (w_wrLane0 && !w_d0[4]) begin
      if (w_d0 == OCW2_NS_EOI) begin
        if (w_isrLow[3]) begin
          w_isrNext[w_isrLow[2:0]] = 1'b0;
        end
      end else if (w_d0[7:5] == OCW2_SPEC_EOI && w_d0[4:3] == 2'b00) begin
        w_isrNext[w_d0[2:0]] = 1'b0;
      end else if (w_d0[4:3] == 2'b01 && w_d0[1]) begin
        w_rdIsrNext = w_d0[0];
      end
    end

    if (inta && w_pendValid) begin
      w_isrNext[w_pendIdx] = 1'b1;
    end

    w_irrNext = w_irrNext | (irq & ~r_irqPrev);

    if (w_wrLane0 && w_d0[4]) begin
      w_irrNext      = 8'h00;
      w_isrNext      = 8'h00;
      w_imrNext      = 8'h00;
      w_rdIsrNext    = 1'b0;
      w_needIcw4Next = w_d0[0];
      w_singleNext   = w_d0[1];
      w_stateNext    = ICW2;
    end

    if (w_wrLane1) begin
      case (w_stateNext)
        READY: w_imrNext = w_d1;
        ICW2: begin
          w_vecBaseNext = w_d1[7:3];
          if (!w_singleNext)       w_stateNext = ICW3;
          else if (w_needIcw4Next) w_stateNext = ICW4;
          else                     w_stateNext = READY;
        end
        ICW3:    w_stateNext = w_needIcw4Next ? ICW4 : READY;
        default: w_stateNext = READY;
      endcase
    end

    w_dataOutNext = 16'h0000;
    if (w_rdValid) begin
      if (bus.data_m_bytesel[0]) w_dataOutNext[7:0]  = r_rdIsr ? r_isr : r_irr;
      if (bus.data_m_bytesel[1]) w_dataOutNext[15:8] = r_imr;
    end
  end

  // Register every piece of controller state, including the outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= READY;
      r_irr      <= 8'h00;
      r_isr      <= 8'h00;
      r_imr      <= 8'hFF;
      r_vecBase  <= 5'h01;
      r_rdIsr    <= 1'b0;
      r_needIcw4 <= 1'b0;
      r_single   <= 1'b0;
      r_irqPrev  <= 8'hFF;
      r_vector   <= 8'h00;
      r_intr     <= 1'b0;
      r_ack      <= 1'b0;
      r_dataOut  <= 16'h0000;
    end else begin
      r_state    <= w_stateNext;
      r_irr      <= w_irrNext;
      r_isr      <= w_isrNext;
      r_imr      <= w_imrNext;
      r_vecBase  <= w_vecBaseNext;
      r_rdIsr    <= w_rdIsrNext;
      r_needIcw4 <= w_needIcw4Next;
      r_single   <= w_singleNext;
      r_irqPrev  <= irq;
      r_vector   <= w_vectorNext;
      r_intr     <= w_pendAllowed;
      r_ack      <= w_access;
      r_dataOut  <= w_dataOutNext;
    end
  end

  assign intr                = r_intr;
  assign irq_vector          = r_vector;
  assign bus.data_m_ack      = r_ack;
  assign bus.data_m_data_out = r_dataOut;

endmodule

// File: tb/tb_irq_controller.sv
// Directed self-checking bench for irq_controller.
module tb_irq_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] irq;
  logic       inta;
  logic       intr;
  logic [7:0] irq_vector;
  logic [15:0] rdData;
  int passCount = 0;
  int checkCount = 0;

  irq_controller_if bus ();

  irq_controller #(.NUM_LINES(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .irq        (irq),
    .inta       (inta),
    .intr       (intr),
    .irq_vector (irq_vector)
  );

  // Free-running 10-time-unit clock.
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    checkCount++;
    if (observed !== expected)
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    else
      passCount++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic busIdle();
    bus.cs             = 1'b0;
    bus.data_m_access  = 1'b0;
    bus.data_m_wr_en   = 1'b0;
    bus.data_m_bytesel = 2'b00;
    bus.data_m_addr    = 1'b0;
    bus.data_m_data_in = 16'h0000;
  endtask

  task automatic busWrite(input logic [1:0] sel, input logic [15:0] data);
    bus.cs             = 1'b1;
    bus.data_m_access  = 1'b1;
    bus.data_m_wr_en   = 1'b1;
    bus.data_m_bytesel = sel;
    bus.data_m_addr    = 1'b0;
    bus.data_m_data_in = data;
    step();
    busIdle();
  endtask

  task automatic busRead(input logic [1:0] sel, input logic addrBit, output logic [15:0] data);
    bus.cs             = 1'b1;
    bus.data_m_access  = 1'b1;
    bus.data_m_wr_en   = 1'b0;
    bus.data_m_bytesel = sel;
    bus.data_m_addr    = addrBit;
    step();
    checkOutput("read_ack", {15'd0, bus.data_m_ack}, 16'h0001);
    data = bus.data_m_data_out;
    busIdle();
  endtask

  task automatic applyStimulus(input logic [7:0] irqValue);
    irq = irqValue;
    step();
  endtask

  task automatic pulseInta();
    inta = 1'b1;
    step();
    inta = 1'b0;
  endtask

  task automatic initSequence();
    busWrite(2'b01, 16'h0013);
    busWrite(2'b10, 16'h0800);
    busWrite(2'b10, 16'h0100);
  endtask

  initial begin
    reset = 1'b0;
    irq   = 8'h00;
    inta  = 1'b0;
    busIdle();
    step();
    step();
    checkOutput("rst_intr", {15'd0, intr}, 16'h0000);
    checkOutput("rst_vector", {8'd0, irq_vector}, 16'h0000);
    checkOutput("rst_ack", {15'd0, bus.data_m_ack}, 16'h0000);
    checkOutput("rst_dout", bus.data_m_data_out, 16'h0000);
    reset = 1'b1;
    step();
    busRead(2'b10, 1'b0, rdData);
    checkOutput("rst_imr", rdData, 16'hFF00);

    // Basic service on line 0.
    initSequence();
    busRead(2'b10, 1'b0, rdData);
    checkOutput("init_imr", rdData, 16'h0000);
    busWrite(2'b10, 16'hFE00);
    applyStimulus(8'h01);
    checkOutput("basic_intr_n", {15'd0, intr}, 16'h0000);
    applyStimulus(8'h00);
    checkOutput("basic_intr_n1", {15'd0, intr}, 16'h0001);
    pulseInta();
    checkOutput("basic_vec", {8'd0, irq_vector}, 16'h0008);
    applyStimulus(8'h00);
    checkOutput("basic_intr_drop", {15'd0, intr}, 16'h0000);
    busWrite(2'b01, 16'h000B);
    busRead(2'b01, 1'b0, rdData);
    checkOutput("basic_isr", rdData, 16'h0001);
    busWrite(2'b01, 16'h0020);
    busRead(2'b01, 1'b0, rdData);
    checkOutput("basic_eoi", rdData, 16'h0000);

    // Priority and nesting: line 1 beats line 3.
    busWrite(2'b10, 16'h0000);
    applyStimulus(8'h08);
    applyStimulus(8'h0A);
    applyStimulus(8'h00);
    checkOutput("prio_intr", {15'd0, intr}, 16'h0001);
    pulseInta();
    checkOutput("prio_vec1", {8'd0, irq_vector}, 16'h0009);
    pulseInta();
    checkOutput("prio_vec2", {8'd0, irq_vector}, 16'h000B);
    busRead(2'b01, 1'b0, rdData);
    checkOutput("prio_isr", rdData, 16'h000A);
    busWrite(2'b01, 16'h0020);
    busRead(2'b01, 1'b0, rdData);
    checkOutput("prio_eoi", rdData, 16'h0008);
    busWrite(2'b01, 16'h0063);
    busRead(2'b01, 1'b0, rdData);
    checkOutput("prio_spec_eoi", rdData, 16'h0000);

    // Masked line still latches but does not interrupt.
    busWrite(2'b10, 16'hFF00);
    applyStimulus(8'h20);
    applyStimulus(8'h00);
    busWrite(2'b01, 16'h000A);
    busRead(2'b01, 1'b0, rdData);
    checkOutput("mask_irr", rdData, 16'h0020);
    checkOutput("mask_intr", {15'd0, intr}, 16'h0000);
    busWrite(2'b10, 16'hDF00);
    checkOutput("unmask_intr_n", {15'd0, intr}, 16'h0000);
    applyStimulus(8'h00);
    checkOutput("unmask_intr_n1", {15'd0, intr}, 16'h0001);
    pulseInta();
    checkOutput("mask_vec", {8'd0, irq_vector}, 16'h000D);

    // Spurious acknowledge leaves isr alone.
    pulseInta();
    checkOutput("spur_vec", {8'd0, irq_vector}, 16'h000F);
    busWrite(2'b01, 16'h000B);
    busRead(2'b01, 1'b0, rdData);
    checkOutput("spur_isr", rdData, 16'h0020);
    busWrite(2'b01, 16'h0020);
    busRead(2'b01, 1'b0, rdData);
    checkOutput("spur_eoi", rdData, 16'h0000);
    busRead(2'b11, 1'b1, rdData);
    checkOutput("addr_ignored", rdData, 16'h0000);

    // New edge on line 2 during its own acknowledge.
    busWrite(2'b10, 16'h0000);
    applyStimulus(8'h04);
    applyStimulus(8'h00);
    irq  = 8'h04;
    inta = 1'b1;
    step();
    inta = 1'b0;
    irq  = 8'h00;
    checkOutput("edge_vec", {8'd0, irq_vector}, 16'h000A);
    busWrite(2'b01, 16'h000A);
    busRead(2'b01, 1'b0, rdData);
    checkOutput("edge_irr", rdData, 16'h0004);
    busWrite(2'b01, 16'h000B);
    busRead(2'b01, 1'b0, rdData);
    checkOutput("edge_isr", rdData, 16'h0004);
    checkOutput("edge_intr", {15'd0, intr}, 16'h0000);

    // EOI and acknowledge in the same cycle.
    applyStimulus(8'h02);
    applyStimulus(8'h00);
    bus.cs             = 1'b1;
    bus.data_m_access  = 1'b1;
    bus.data_m_wr_en   = 1'b1;
    bus.data_m_bytesel = 2'b01;
    bus.data_m_data_in = 16'h0020;
    inta               = 1'b1;
    step();
    inta = 1'b0;
    busIdle();
    checkOutput("eoi_inta_vec", {8'd0, irq_vector}, 16'h0009);
    busRead(2'b01, 1'b0, rdData);
    checkOutput("eoi_inta_isr", rdData, 16'h0002);
    busWrite(2'b01, 16'h000A);
    busRead(2'b01, 1'b0, rdData);
    checkOutput("eoi_inta_irr", rdData, 16'h0004);

    // Reset in the middle of initialisation.
    busWrite(2'b01, 16'h0013);
    reset = 1'b0;
    step();
    reset = 1'b1;
    step();
    busRead(2'b10, 1'b0, rdData);
    checkOutput("midinit_imr", rdData, 16'hFF00);
    busWrite(2'b10, 16'h5500);
    busRead(2'b10, 1'b0, rdData);
    checkOutput("midinit_ready", rdData, 16'h5500);
    pulseInta();
    checkOutput("midinit_vec", {8'd0, irq_vector}, 16'h000F);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
